// File: rtl/sev_seg_reader.sv
// Seven-segment display reader: synchronizes the active-low segment and
// digit-enable pins, waits for a stable vector, and captures the decoded
// hex value (or flags an illegal pattern) for the enabled digit.
module sev_seg_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] segIn,
    input  logic [1:0] digitEn,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [1:0] valid,
    output logic [1:0] patErr,
    output logic       update,
    output logic       updDigit
);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HELD
    } state_e;

    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

    logic [6:0] seg_s1_q, seg_s2_q;
    logic [1:0] en_s1_q, en_s2_q;
    logic [8:0] prev_q;
    state_e     state_q;
    logic [7:0] cnt_q;
    logic [3:0] digit0_q, digit1_q;
    logic [1:0] valid_q, patErr_q;
    logic       update_q, updDigit_q;

    logic [8:0] v_d;
    logic       en_ok_d, sel_d, dec_ok_d;
    logic [3:0] dec_val_d;

    // Two-flop synchronizers; cleared to all-ones (blank segments, no digit enabled)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_s1_q <= '1;
            seg_s2_q <= '1;
            en_s1_q  <= '1;
            en_s2_q  <= '1;
        end else begin
            seg_s1_q <= segIn;
            seg_s2_q <= seg_s1_q;
            en_s1_q  <= digitEn;
            en_s2_q  <= en_s1_q;
        end
    end

    // Decode the synchronized segment pattern and qualify the digit enable
    always_comb begin
        v_d       = {seg_s2_q, en_s2_q};
        en_ok_d   = (en_s2_q == 2'b10) || (en_s2_q == 2'b01);
        sel_d     = (en_s2_q == 2'b01);
        dec_ok_d  = 1'b1;
        dec_val_d = '0;
        case (seg_s2_q)
            7'b1000000: dec_val_d = 4'h0;
            7'b1111001: dec_val_d = 4'h1;
            7'b0100100: dec_val_d = 4'h2;
            7'b0110000: dec_val_d = 4'h3;
            7'b0011001: dec_val_d = 4'h4;
            7'b0010010: dec_val_d = 4'h5;
            7'b0000010: dec_val_d = 4'h6;
            7'b1111000: dec_val_d = 4'h7;
            7'b0000000: dec_val_d = 4'h8;
            7'b0011000: dec_val_d = 4'h9;
            7'b0100000: dec_val_d = 4'hA;
            7'b0000011: dec_val_d = 4'hB;
            7'b1000110: dec_val_d = 4'hC;
            7'b0100001: dec_val_d = 4'hD;
            7'b0000110: dec_val_d = 4'hE;
            7'b0001110: dec_val_d = 4'hF;
            default:    dec_ok_d  = 1'b0;
        endcase
    end

    // Stability tracker and capture FSM with registered outputs.
    // The counter holds at STABLE_CYCLES once reached, so HELD dwell never wraps it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prev_q     <= '1;
            digit0_q   <= '0;
            digit1_q   <= '0;
            valid_q    <= '0;
            patErr_q   <= '0;
            update_q   <= 1'b0;
            updDigit_q <= 1'b0;
        end else begin
            prev_q   <= v_d;
            update_q <= 1'b0;
            if (!en_ok_d) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= TRACK;
                        cnt_q   <= 8'd1;
                    end
                    TRACK: begin
                        if (v_d != prev_q) begin
                            cnt_q <= 8'd1;
                        end else if (cnt_q >= STABLE_LIM) begin
                            state_q    <= HELD;
                            update_q   <= 1'b1;
                            updDigit_q <= sel_d;
                            if (dec_ok_d) begin
                                if (sel_d) digit1_q <= dec_val_d;
                                else       digit0_q <= dec_val_d;
                                valid_q[sel_d] <= 1'b1;
                            end else begin
                                valid_q[sel_d]  <= 1'b0;
                                patErr_q[sel_d] <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    HELD: begin
                        if (v_d != prev_q) begin
                            state_q <= TRACK;
                            cnt_q   <= 8'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign digit0   = digit0_q;
    assign digit1   = digit1_q;
    assign valid    = valid_q;
    assign patErr   = patErr_q;
    assign update   = update_q;
    assign updDigit = updDigit_q;

endmodule

// File: doc/sev_seg_reader.md
SEV_SEG_READER -- requirements
Module: sev_seg_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive clock edges a synchronized input vector must hold before capture; legal range 2..255.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 segIn  input  7  segment lines, active-low, bit0=a through bit6=g.
REQ-005 digitEn  input  2  per-digit enables, active-low; bit0=digit0, bit1=digit1.
REQ-006 digit0, digit1  output  4 each  last accepted hex value per digit.
REQ-007 valid  output  2  bit n=1: digit n holds a legally decoded value.
REQ-008 patErr  output  2  sticky flag; bit n=1: an illegal stable pattern was seen on digit n.
REQ-009 update  output  1  one-cycle pulse on any capture, legal or illegal.
REQ-010 updDigit  output  1  index of the digit captured; qualified by update.

Function
REQ-011 segIn and digitEn shall each pass through a two-flop synchronizer; all further logic shall use only the synchronized vector V = {segIn, digitEn}.
REQ-012 Legal patterns, hex 0-F in order:
  1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000,
  0000000, 0011000, 0100000, 0000011, 1000110, 0100001, 0000110, 0001110.
  Any other 7-bit value is illegal.
REQ-013 Enable qualification: digitEn = 2'b10 selects digit0 and 2'b01 selects digit1. 2'b11 (none) and 2'b00 (both) are invalid.
REQ-014 State machine IDLE/TRACK/HELD:
  - Any state, V enable invalid -> IDLE, counter = 0.
  - IDLE, valid enable -> TRACK, counter = 1.
  - TRACK, V equal to its previous value -> counter += 1.
  - TRACK, V changed with valid enable -> stay in TRACK, counter = 1.
  - TRACK, counter reaches STABLE_CYCLES -> capture, go to HELD.
  - HELD, V unchanged -> stay in HELD; no re-capture.
  - HELD, V changed with valid enable -> TRACK, counter = 1.
REQ-015 Capture latency: pins stable from rising edge k give an update pulse high during the cycle after edge k+2+STABLE_CYCLES (6 cycles at default).
REQ-016 Legal capture of digit n: digit n = decoded value, valid[n] = 1, patErr[n] unchanged.
REQ-017 Illegal capture of digit n: digit n unchanged, valid[n] = 0, patErr[n] = 1.
REQ-018 Each capture: update = 1 and updDigit = n for exactly one cycle; the other digit's outputs are unchanged.
REQ-019 patErr[n] shall clear only on reset.
REQ-020 The counter shall saturate and never wrap, whatever the dwell time in HELD.
REQ-021 Only synchronized values are compared; a glitch shorter than one clock that is never sampled has no effect.

Reset
REQ-022 While reset = 0, the following hold asynchronously:
  - state = IDLE, counter = 0, synchronizers cleared to all-ones (blank, no enable);
  - digit0 = digit1 = 0, valid = 00, patErr = 00, update = 0, updDigit = 0.
REQ-023 Reset asserted mid-TRACK shall abort the capture. After release, a fresh STABLE_CYCLES window is required.

Verification
REQ-024 Basic capture: segIn = 0100100, digitEn = 10, held from edge 0 -> update = 1 in cycle 6, updDigit = 0, digit0 = 2, valid = 01. Holding the inputs 20 more cycles gives no further pulse.
REQ-025 Alternating digits: digitEn = 01 with segIn = 0001110 for 10 cycles, then digitEn = 10 with segIn = 1111000 for 10 cycles -> digit1 = F, digit0 = 7, valid = 11, two update pulses, with updDigit = 1 then 0.
REQ-026 Illegal pattern: segIn = 1111111, digitEn = 10 stable for 10 cycles -> update pulse, patErr = 01, valid[0] = 0, digit0 unchanged. A later legal 0 capture -> valid[0] = 1, patErr still 01.
REQ-027 Instability and invalid enable:
  - segIn toggling every 3 cycles between 0 and 8 -> no update at STABLE_CYCLES = 4.
  - digitEn = 00 for 10 cycles -> no update, state IDLE.
REQ-028 Reset mid-operation: reset = 0 at cycle 3 of a TRACK window, released at cycle 5, inputs held -> all outputs zero during reset. The first update occurs 6 cycles after release edge alignment, never earlier.
